program_loader: RTL and testbench



---
 rtl/program_loader_pkg.sv | 25 ++
 rtl/program_loader_if.sv | 22 ++
 rtl/program_loader_word_assembler.sv | 45 ++++
 rtl/program_loader.sv | 140 ++++++++++++++
 tb/tb_program_loader.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the serial program loader.
package loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    CNT_HI,
    CNT_LO,
    DATA,
    WRITE,
    CSUM,
    RUN,
    ERR
  } state_e;

  localparam logic [7:0]  SYNC_BYTE_DEF  = 8'hA5;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned BYTES_PER_WORD = DATA_W_DEF / 8;

  function automatic int unsigned bytes_per_word(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
interface program_loader_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              w_enable;
  logic [ADDR_W-1:0] w_adrs;
  logic [DATA_W-1:0] w_instruction;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, w_enable, w_adrs, w_instruction
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, w_enable, w_adrs, w_instruction
  );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Shifts accepted bytes MSB-first into a word and flags the word's last byte.
module word_assembler
  import loader_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_done_o
);
  localparam int unsigned BPW = bytes_per_word(DATA_W);
  localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_W-1:0] word_q, word_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // word_o already includes the byte being accepted this cycle
  always_comb begin
    word_o      = (word_q << 8) | DATA_W'(byte_i);
    word_done_o = shift_i && !clear_i && (cnt_q == CW'(BPW - 1));
    word_d      = word_q;
    cnt_d       = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (shift_i) begin
      word_d = word_o;
      cnt_d  = word_done_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader: writes words to instruction memory and releases
// the CPU only after the frame checksum matches.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 32,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  program_loader_if.slave  bus,
  output logic             cpu_en,
  output logic             busy,
  output logic             error
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        csum_q, csum_d;
  logic              err_q, err_d;
  logic              rdy_q;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;

  logic              hs, is_sync, word_done;
  logic [DATA_W-1:0] word;

  assign hs      = bus.rx_valid && bus.rx_ready;
  assign is_sync = (bus.rx_data == SYNC_BYTE);

  word_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (state_q != DATA && state_q != WRITE),
    .shift_i    (hs && state_q == DATA),
    .byte_i     (bus.rx_data),
    .word_o     (word),
    .word_done_o(word_done)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    csum_d  = csum_q;
    err_d   = err_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    unique case (state_q)
      IDLE: if (hs && is_sync) begin
        state_d = ADDR_HI;
        csum_d  = '0;
      end
      ADDR_HI: if (hs) begin
        hi_d    = bus.rx_data;
        csum_d  = csum_q ^ bus.rx_data;
        state_d = ADDR_LO;
      end
      ADDR_LO: if (hs) begin
        addr_d  = ADDR_W'({hi_q, bus.rx_data});
        csum_d  = csum_q ^ bus.rx_data;
        state_d = CNT_HI;
      end
      CNT_HI: if (hs) begin
        hi_d    = bus.rx_data;
        csum_d  = csum_q ^ bus.rx_data;
        state_d = CNT_LO;
      end
      CNT_LO: if (hs) begin
        cnt_d   = {hi_q, bus.rx_data};
        csum_d  = csum_q ^ bus.rx_data;
        state_d = ({hi_q, bus.rx_data} == 16'd0) ? CSUM : DATA;
      end
      // write port registers latch here so they hold between strobes
      DATA: if (hs) begin
        csum_d = csum_q ^ bus.rx_data;
        if (word_done) begin
          wa_d    = addr_q;
          wd_d    = word;
          state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q - 16'd1;
        state_d = (cnt_q == 16'd1) ? CSUM : DATA;
      end
      CSUM: if (hs) begin
        if (bus.rx_data == csum_q) begin
          state_d = RUN;
        end else begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      RUN, ERR: if (hs && is_sync) begin
        state_d = ADDR_HI;
        csum_d  = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      csum_q  <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      csum_q  <= csum_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.rx_ready      = rdy_q && (state_q != WRITE);
  assign bus.w_enable      = (state_q == WRITE);
  assign bus.w_adrs        = wa_q;
  assign bus.w_instruction = wd_q;
  assign cpu_en            = (state_q == RUN);
  assign busy              = !(state_q inside {IDLE, RUN, ERR});
  assign error             = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader with a frame-level model.
module tb_program_loader;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_en, busy, error;

  program_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  program_loader #(.ADDR_W(AW), .DATA_W(DW), .SYNC_BYTE(8'hA5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .cpu_en(cpu_en),
    .busy  (busy),
    .error (error)
  );

  always #5 clk = ~clk;

  typedef enum int {K_NOISE, K_SYNC, K_HDR, K_DATA, K_LAST, K_CSUM_OK, K_CSUM_BAD} kind_e;
  typedef struct {
    logic [7:0]    b;
    kind_e         k;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } desc_t;
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  desc_t exp_q[$];
  wr_t   wlog[$];
  logic [DW-1:0] words[16];
  int checks = 0;
  int failures = 0;

  // frame-level expectations, updated when a tagged byte is accepted
  bit            m_wen, m_cpu, m_busy, m_err, m_rdy;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic desc_t mk(input logic [7:0] b, input kind_e k,
                               input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    desc_t d;
    d.b = b; d.k = k; d.wa = wa; d.wd = wd;
    return d;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      chk("reset_outputs", 64'({bus.rx_ready, bus.w_enable, cpu_en, busy, error,
                                bus.w_adrs, bus.w_instruction}), 64'd0);
      m_wen = 0; m_cpu = 0; m_busy = 0; m_err = 0; m_rdy = 0;
      m_a = '0; m_d = '0;
      exp_q.delete();
    end else begin
      if (bus.w_enable) wlog.push_back('{bus.w_adrs, bus.w_instruction});
      chk("w_enable", 64'(bus.w_enable), 64'(m_wen));
      chk("w_adrs", 64'(bus.w_adrs), 64'(m_a));
      chk("w_instruction", 64'(bus.w_instruction), 64'(m_d));
      chk("cpu_en", 64'(cpu_en), 64'(m_cpu));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("error", 64'(error), 64'(m_err));
      chk("rx_ready", 64'(bus.rx_ready), 64'(m_rdy && !m_wen));
      m_wen = 0;
      if (bus.rx_valid && bus.rx_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_accept", 64'd1, 64'd0);
        end else begin
          desc_t d;
          d = exp_q.pop_front();
          case (d.k)
            K_SYNC:     begin m_busy = 1; m_cpu = 0; m_err = 0; end
            K_LAST:     begin m_wen = 1; m_a = d.wa; m_d = d.wd; end
            K_CSUM_OK:  begin m_busy = 0; m_cpu = 1; end
            K_CSUM_BAD: begin m_busy = 0; m_err = 1; end
            default: ;
          endcase
        end
      end
      m_rdy = 1;
    end
  end

  // called and returns at posedge+2; byte is offered until accepted
  task automatic drive(input desc_t d, input int unsigned gapmax);
    int unsigned g, bound;
    bit acc;
    g = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
    repeat (g) begin
      bus.rx_valid = 1'b0;
      @(posedge clk); #2;
    end
    exp_q.push_back(d);
    bus.rx_data  = d.b;
    bus.rx_valid = 1'b1;
    bound = 0;
    forever begin
      @(negedge clk);
      acc = bus.rx_ready;
      @(posedge clk); #2;
      if (acc) break;
      bound++;
      if (bound > 40) begin
        chk("accept_timeout", 64'd0, 64'd1);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        break;
      end
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] n, input bit bad,
                            input int unsigned gap, input bit with_sync);
    logic [7:0]    cs, b;
    logic [7:0]    hdr[4];
    logic [AW-1:0] wa;
    logic [DW-1:0] w;
    cs = 8'h00;
    if (with_sync) drive(mk(8'hA5, K_SYNC, '0, '0), gap);
    hdr[0] = a[15:8]; hdr[1] = a[7:0]; hdr[2] = n[15:8]; hdr[3] = n[7:0];
    for (int i = 0; i < 4; i++) begin
      cs ^= hdr[i];
      drive(mk(hdr[i], K_HDR, '0, '0), gap);
    end
    for (int unsigned i = 0; i < n; i++) begin
      w  = words[i];
      wa = AW'((32'(a) + i) % (32'd1 << AW));
      for (int j = 0; j < 4; j++) begin
        b = w[31-8*j -: 8];
        cs ^= b;
        drive(mk(b, (j == 3) ? K_LAST : K_DATA, wa, w), gap);
      end
    end
    drive(mk(cs ^ (bad ? 8'h01 : 8'h00), bad ? K_CSUM_BAD : K_CSUM_OK, '0, '0), gap);
  endtask

  initial begin
    logic [7:0] nb;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("ready_in_reset", 64'(bus.rx_ready), 64'd0);
    reset = 1'b0;
    @(posedge clk); #2;
    chk("ready_after_reset", 64'(bus.rx_ready), 64'd1);

    // noise in IDLE
    drive(mk(8'h00, K_NOISE, '0, '0), 0);
    drive(mk(8'hFF, K_NOISE, '0, '0), 0);
    drive(mk(8'h12, K_NOISE, '0, '0), 0);
    chk("noise_busy", 64'(busy), 64'd0);
    chk("noise_writes", 64'(wlog.size()), 64'd0);

    // two-word load
    words[0] = 32'hE000_0064;
    words[1] = 32'hE000_0065;
    send_frame(16'h0001, 16'd2, 1'b0, 0, 1'b1);
    chk("load_nwrites", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      chk("load_w0", 64'({wlog[0].a, wlog[0].d}), 64'({11'h001, 32'hE000_0064}));
      chk("load_w1", 64'({wlog[1].a, wlog[1].d}), 64'({11'h002, 32'hE000_0065}));
    end
    chk("load_cpu_en", 64'(cpu_en), 64'd1);
    chk("load_error", 64'(error), 64'd0);

    // bad checksum (CSUM 03), then empty frame with CSUM 0A
    wlog.delete();
    send_frame(16'h0001, 16'd2, 1'b1, 0, 1'b1);
    chk("bad_nwrites", 64'(wlog.size()), 64'd2);
    chk("bad_cpu_en", 64'(cpu_en), 64'd0);
    chk("bad_error", 64'(error), 64'd1);
    send_frame(16'h000A, 16'd0, 1'b0, 0, 1'b1);
    chk("empty_error", 64'(error), 64'd0);
    chk("empty_cpu_en", 64'(cpu_en), 64'd1);
    chk("empty_nwrites", 64'(wlog.size()), 64'd2);

    // address wrap with random valid gaps
    wlog.delete();
    words[0] = $urandom;
    words[1] = $urandom;
    send_frame(16'h07FF, 16'd2, 1'b0, 3, 1'b1);
    chk("wrap_nwrites", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      chk("wrap_w0", 64'({wlog[0].a, wlog[0].d}), 64'({11'h7FF, words[0]}));
      chk("wrap_w1", 64'({wlog[1].a, wlog[1].d}), 64'({11'h000, words[1]}));
    end

    // reload while running
    drive(mk(8'hA5, K_SYNC, '0, '0), 0);
    chk("reload_cpu_en", 64'(cpu_en), 64'd0);
    chk("reload_busy", 64'(busy), 64'd1);
    words[0] = 32'hA5A5_A5A5;
    send_frame(16'h0100, 16'd1, 1'b0, 2, 1'b0);
    chk("reload_done_cpu_en", 64'(cpu_en), 64'd1);

    // reset after two data bytes
    wlog.delete();
    drive(mk(8'hA5, K_SYNC, '0, '0), 0);
    drive(mk(8'h00, K_HDR, '0, '0), 0);
    drive(mk(8'h20, K_HDR, '0, '0), 0);
    drive(mk(8'h00, K_HDR, '0, '0), 0);
    drive(mk(8'h01, K_HDR, '0, '0), 0);
    drive(mk(8'hDE, K_DATA, '0, '0), 0);
    drive(mk(8'hAD, K_DATA, '0, '0), 0);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_outputs", 64'({bus.rx_ready, bus.w_enable, cpu_en, busy, error,
                                    bus.w_adrs, bus.w_instruction}), 64'd0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;
    chk("reset_no_write", 64'(wlog.size()), 64'd0);
    words[0] = $urandom;
    send_frame(16'h0020, 16'd1, 1'b0, 1, 1'b1);
    chk("post_reset_nwrites", 64'(wlog.size()), 64'd1);
    if (wlog.size() == 1)
      chk("post_reset_w0", 64'({wlog[0].a, wlog[0].d}), 64'({11'h020, words[0]}));

    // randomized frames with ignored bytes between them
    for (int f = 0; f < 8; f++) begin
      repeat ($urandom_range(0, 2)) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == 8'hA5) nb = 8'h5A;
        drive(mk(nb, K_NOISE, '0, '0), 1);
      end
      for (int i = 0; i < 4; i++) begin
        words[i] = $urandom;
        if ($urandom_range(0, 3) == 0) words[i][15:8] = 8'hA5;
      end
      send_frame(16'($urandom), 16'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2, 1'b1);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("no_pending_bytes", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
